// File: rtl/wb_plic_lite_pkg.sv
// wb_plic_lite shared definitions: register offsets and gateway states.
// Imported by the top and the per-source gateway.
package wb_plic_lite_pkg;

  localparam int PLIC_MAX_SRC = 31;

  localparam int OFF_PRIO    = 'h000;
  localparam int OFF_PENDING = 'h080;
  localparam int OFF_ENABLE  = 'h100;
  localparam int OFF_THRESH  = 'h180;
  localparam int OFF_CLAIM   = 'h184;
  localparam int OFF_EDGE    = 'h188;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PEND    = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_t;

endpackage

// File: rtl/wb_plic_lite_gateway.sv
// wb_plic_lite per-source gateway: IDLE -> PEND -> CLAIMED -> IDLE.
// Optional edge latch when PLIC_EDGE_TRIG_EN is defined.
//
// Ports:
//  clk, rst    clock, synchronous active-high reset
//  irq         raw level request from the peripheral
//  edge_mode   1 = edge-triggered (only with PLIC_EDGE_TRIG_EN)
//  claim       this source won a claim read this cycle
//  complete    complete write carried this source's ID
//  pend        gateway is in PEND
//  claimed     gateway is in CLAIMED
module wb_plic_lite_gateway
  import wb_plic_lite_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic edge_mode,
  input  logic claim,
  input  logic complete,
  output logic pend,
  output logic claimed
);

  gw_state_t st_q;
  gw_state_t st_d;
  logic      trig;

`ifdef PLIC_EDGE_TRIG_EN
  logic prev_q;
  logic latch_q;
  logic rise;
  logic consume;

  assign rise    = irq & ~prev_q;
  // Latch is taken only in IDLE; a fresh edge in the same
  // cycle survives so it is delivered on the next pass.
  assign consume = latch_q & (st_q == GW_IDLE);
  assign trig    = edge_mode ? latch_q : irq;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      prev_q  <= irq;
      if (!edge_mode)
        latch_q <= 1'b0;
      else
        latch_q <= rise | (latch_q & ~consume);
    end
  end
`else
  logic unused_edge;
  assign unused_edge = edge_mode;
  assign trig        = irq;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      st_q <= GW_IDLE;
    else
      st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      GW_IDLE:    if (trig)     st_d = GW_PEND;
      GW_PEND:    if (claim)    st_d = GW_CLAIMED;
      GW_CLAIMED: if (complete) st_d = GW_IDLE;
      default:                  st_d = GW_IDLE;
    endcase
  end

  assign pend    = (st_q == GW_PEND);
  assign claimed = (st_q == GW_CLAIMED);

endmodule

// File: rtl/wb_plic_lite.sv
// wb_plic_lite: Wishbone-slave platform interrupt controller.
// Gateways per source, priority/enable/threshold, claim/complete.
//
// Optional feature macro: PLIC_EDGE_TRIG_EN (adds EDGE_CFG reg).
// Ports:
//  clk, rst           clock, synchronous active-high reset
//  irq_src_i          level requests; bit k is source ID k+1
//  plic_core_irq_o    registered external irq to the core
//  wbm_plic_*_i       Wishbone slave inputs (sel ignored)
//  plic_wbm_rdata_o   read data, valid with ack
//  plic_wbm_ack_o     single-cycle ack
module wb_plic_lite
  import wb_plic_lite_pkg::*;
#(
  parameter int NUM_SRC      = 8,
  parameter int PRIO_W       = 3,
  parameter int WB_AD_WIDTH  = 32,
  parameter int WB_DAT_WIDTH = 32,
  parameter logic [WB_AD_WIDTH-1:0] BASE = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        irq_src_i,
  output logic                      plic_core_irq_o,
  input  logic                      wbm_plic_cyc_i,
  input  logic                      wbm_plic_stb_i,
  input  logic [WB_AD_WIDTH-1:0]    wbm_plic_addr_i,
  input  logic [WB_DAT_WIDTH-1:0]   wbm_plic_wdata_i,
  input  logic [WB_DAT_WIDTH/8-1:0] wbm_plic_sel_i,
  input  logic                      wbm_plic_we_i,
  output logic [WB_DAT_WIDTH-1:0]   plic_wbm_rdata_o,
  output logic                      plic_wbm_ack_o
);

  localparam int ID_W = $clog2(NUM_SRC + 1);

  logic [NUM_SRC:1][PRIO_W-1:0] prio_q;
  logic [NUM_SRC:1]             en_q;
  logic [NUM_SRC:1]             edge_q;
  logic [PRIO_W-1:0]            thresh_q;
  logic [NUM_SRC:1]             pend;
  logic [NUM_SRC:1]             claimed;

  logic                    ack_q;
  logic                    done_q;
  logic [WB_DAT_WIDTH-1:0] rdata_q;
  logic                    req;
  logic [WB_AD_WIDTH-1:0]  off;

  logic [NUM_SRC:1]        prio_hit;
  logic                    en_hit;
  logic                    th_hit;
  logic                    clm_hit;
  logic                    edge_hit;
  logic [WB_DAT_WIDTH-1:0] rd_val;

  logic [ID_W-1:0]   win_id;
  logic [PRIO_W-1:0] win_prio;
  logic              claim_go;
  logic              cmpl_go;

  logic unused_sel;
  logic unused_claimed;
  assign unused_sel     = ^wbm_plic_sel_i;
  assign unused_claimed = ^claimed;

  // One transaction per cyc&stb assertion: done_q blocks a
  // held strobe from re-triggering after its ack.
  assign req = wbm_plic_cyc_i & wbm_plic_stb_i
             & ~ack_q & ~done_q;
  assign off = wbm_plic_addr_i - BASE;

  assign claim_go = req & ~wbm_plic_we_i & clm_hit;
  assign cmpl_go  = req &  wbm_plic_we_i & clm_hit;

  // Ascending scan with strict '>' gives lowest ID on ties;
  // starting at 0 excludes priority-0 sources.
  always_comb begin
    win_id   = '0;
    win_prio = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (pend[i] && en_q[i] && (prio_q[i] > win_prio)) begin
        win_id   = ID_W'(i);
        win_prio = prio_q[i];
      end
    end
  end

  always_comb begin
    prio_hit = '0;
    en_hit   = 1'b0;
    th_hit   = 1'b0;
    clm_hit  = 1'b0;
    edge_hit = 1'b0;
    rd_val   = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (off == WB_AD_WIDTH'(OFF_PRIO + 4 * (i - 1))) begin
        prio_hit[i]          = 1'b1;
        rd_val[PRIO_W-1:0]   = prio_q[i];
      end
    end
    if (off == WB_AD_WIDTH'(OFF_PENDING))
      rd_val[NUM_SRC:1] = pend;
    if (off == WB_AD_WIDTH'(OFF_ENABLE)) begin
      en_hit            = 1'b1;
      rd_val[NUM_SRC:1] = en_q;
    end
    if (off == WB_AD_WIDTH'(OFF_THRESH)) begin
      th_hit             = 1'b1;
      rd_val[PRIO_W-1:0] = thresh_q;
    end
    if (off == WB_AD_WIDTH'(OFF_CLAIM)) begin
      clm_hit          = 1'b1;
      rd_val[ID_W-1:0] = win_id;
    end
`ifdef PLIC_EDGE_TRIG_EN
    if (off == WB_AD_WIDTH'(OFF_EDGE)) begin
      edge_hit          = 1'b1;
      rd_val[NUM_SRC:1] = edge_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
      prio_q   <= '0;
      en_q     <= '0;
      thresh_q <= '0;
      plic_core_irq_o <= 1'b0;
    end else begin
      ack_q   <= req;
      done_q  <= wbm_plic_cyc_i & wbm_plic_stb_i
               & (ack_q | done_q);
      rdata_q <= (req && !wbm_plic_we_i) ? rd_val : '0;
      if (req && wbm_plic_we_i) begin
        for (int i = 1; i <= NUM_SRC; i++)
          if (prio_hit[i])
            prio_q[i] <= wbm_plic_wdata_i[PRIO_W-1:0];
        if (en_hit)
          en_q <= wbm_plic_wdata_i[NUM_SRC:1];
        if (th_hit)
          thresh_q <= wbm_plic_wdata_i[PRIO_W-1:0];
      end
      plic_core_irq_o <= (win_id != '0)
                       && (win_prio > thresh_q);
    end
  end

`ifdef PLIC_EDGE_TRIG_EN
  always_ff @(posedge clk) begin
    if (rst)
      edge_q <= '0;
    else if (req && wbm_plic_we_i && edge_hit)
      edge_q <= wbm_plic_wdata_i[NUM_SRC:1];
  end
`else
  logic unused_edge_hit;
  assign unused_edge_hit = edge_hit;
  assign edge_q          = '0;
`endif

  for (genvar k = 1; k <= NUM_SRC; k++) begin : g_gw
    wb_plic_lite_gateway u_gw (
      .clk      (clk),
      .rst      (rst),
      .irq      (irq_src_i[k-1]),
      .edge_mode(edge_q[k]),
      .claim    (claim_go && (win_id == ID_W'(k))),
      .complete (cmpl_go &&
                 (wbm_plic_wdata_i == WB_DAT_WIDTH'(k))),
      .pend     (pend[k]),
      .claimed  (claimed[k])
    );
  end

  assign plic_wbm_rdata_o = rdata_q;
  assign plic_wbm_ack_o   = ack_q;

endmodule

// File: tb/tb_wb_plic_lite.sv
// wb_plic_lite bench: directed steps plus a randomized phase
// checked against a behavioural model of sources and claims.
module tb_wb_plic_lite;

  localparam int N = 8;
  localparam logic [31:0] A_PEND = 32'h080;
  localparam logic [31:0] A_EN   = 32'h100;
  localparam logic [31:0] A_TH   = 32'h180;
  localparam logic [31:0] A_CLM  = 32'h184;
  localparam logic [31:0] A_EDGE = 32'h188;

  logic        clk = 1'b0;
  logic        rst;
  logic [N-1:0] irq;
  logic        irq_o;
  logic        cyc, stb, we;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  sel;
  logic        ack;

  int n_asr  = 0;
  int n_fail = 0;

  int mst   [1:N];
  int mprio [1:N];
  logic [N:1] men;
  int mthr;

  always #5 clk = ~clk;

  wb_plic_lite dut (
    .clk             (clk),
    .rst             (rst),
    .irq_src_i       (irq),
    .plic_core_irq_o (irq_o),
    .wbm_plic_cyc_i  (cyc),
    .wbm_plic_stb_i  (stb),
    .wbm_plic_addr_i (addr),
    .wbm_plic_wdata_i(wdata),
    .wbm_plic_sel_i  (sel),
    .wbm_plic_we_i   (we),
    .plic_wbm_rdata_o(rdata),
    .plic_wbm_ack_o  (ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asr++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic w, input logic [31:0] a,
                      input logic [31:0] d,
                      output logic [31:0] r);
    int n = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; addr = a; wdata = d;
    do begin
      @(posedge clk); #1; n++;
    end while (ack !== 1'b1 && n < 16);
    chk("ack_seen", {31'b0, ack}, 32'd1);
    r = rdata;
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    chk("ack_single", {31'b0, ack}, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    xfer(1'b1, a, d, r);
  endtask

  task automatic rdc(input string tag, input logic [31:0] a,
                     input logic [31:0] exp);
    logic [31:0] r;
    xfer(1'b0, a, 32'd0, r);
    chk(tag, r, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; irq = '0; cyc = 0; stb = 0; we = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_irq_o", {31'b0, irq_o}, 32'd0);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 0;
  endtask

  function automatic logic [31:0] pa(input int id);
    return 32'(4 * (id - 1));
  endfunction

  // Reference model: sources as small integers, 0=idle,
  // 1=pending, 2=claimed.
  function automatic int mwin();
    int best = 0;
    int bp   = 0;
    for (int i = 1; i <= N; i++)
      if (mst[i] == 1 && men[i] && mprio[i] > bp) begin
        best = i;
        bp   = mprio[i];
      end
    return best;
  endfunction

  function automatic logic [31:0] mpend();
    logic [31:0] v = '0;
    for (int i = 1; i <= N; i++)
      if (mst[i] == 1) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] mirq();
    int w = mwin();
    return {31'b0, (w != 0) && (mprio[w] > mthr)};
  endfunction

  task automatic settle();
    for (int i = 1; i <= N; i++)
      if (mst[i] == 0 && irq[i-1]) mst[i] = 1;
  endtask

  initial begin
    logic [31:0] r;
    int nack, w, c;
    sel = 4'hf; addr = '0; wdata = '0;

    // Reset defaults
    do_reset();
    rdc("rst_prio3", pa(3), 0);
    rdc("rst_en", A_EN, 0);
    rdc("rst_th", A_TH, 0);
    rdc("rst_pend", A_PEND, 0);
    rdc("rst_claim", A_CLM, 0);

    // Single source, irq latency, claim, complete
    wr(pa(3), 2); wr(A_EN, 32'h08); wr(A_TH, 0);
    @(negedge clk); irq[2] = 1;
    @(posedge clk); #1;
    chk("t1_irq_lat1", {31'b0, irq_o}, 0);
    @(posedge clk); #1;
    chk("t1_irq_lat2", {31'b0, irq_o}, 1);
    rdc("t1_claim", A_CLM, 3);
    rdc("t1_pend_clr", A_PEND, 0);
    chk("t1_irq_drop", {31'b0, irq_o}, 0);
    @(negedge clk); irq[2] = 0;
    wr(A_CLM, 3);
    cycles(2);
    rdc("t1_idle_pend", A_PEND, 0);
    @(negedge clk); irq[2] = 1;
    cycles(3);
    rdc("t1_repend", A_PEND, 32'h08);

    // Priority order and tie-break
    do_reset();
    wr(pa(2), 1); wr(pa(5), 4); wr(A_EN, 32'h24);
    @(negedge clk); irq[1] = 1; irq[4] = 1;
    cycles(3);
    rdc("t2_claim5", A_CLM, 5);
    rdc("t2_claim2", A_CLM, 2);
    rdc("t2_claim0", A_CLM, 0);
    do_reset();
    wr(pa(4), 3); wr(pa(6), 3); wr(A_EN, 32'h50);
    @(negedge clk); irq[3] = 1; irq[5] = 1;
    cycles(3);
    rdc("t2_tie", A_CLM, 4);

    // Threshold, empty claim, disable/re-enable
    do_reset();
    wr(pa(3), 4); wr(A_EN, 32'h08); wr(A_TH, 4);
    @(negedge clk); irq[2] = 1;
    cycles(4);
    chk("t3_th_block", {31'b0, irq_o}, 0);
    wr(A_TH, 3);
    cycles(2);
    chk("t3_th_pass", {31'b0, irq_o}, 1);
    wr(A_EN, 0);
    rdc("t3_claim_none", A_CLM, 0);
    rdc("t3_still_pend", A_PEND, 32'h08);
    wr(A_EN, 32'h08);
    rdc("t3_reenable", A_CLM, 3);

    // Wrong-ID complete, level re-pend
    do_reset();
    wr(pa(3), 1); wr(A_EN, 32'h08);
    @(negedge clk); irq[2] = 1;
    cycles(3);
    rdc("t4_claim", A_CLM, 3);
    wr(A_CLM, 7);
    rdc("t4_wrong_pend", A_PEND, 0);
    rdc("t4_wrong_claim", A_CLM, 0);
    wr(A_CLM, 3);
    rdc("t4_repend", A_PEND, 32'h08);
    chk("t4_irq_re", {31'b0, irq_o}, 1);

    // Held strobe, unmapped access
    do_reset();
    wr(pa(2), 1); wr(pa(5), 4); wr(A_EN, 32'h24);
    @(negedge clk); irq[1] = 1; irq[4] = 1;
    cycles(3);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; addr = A_CLM;
    nack = 0; r = '0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin nack++; r = rdata; end
    end
    @(negedge clk); cyc = 0; stb = 0;
    cycles(1);
    chk("t5_acks", 32'(nack), 1);
    chk("t5_id", r, 5);
    rdc("t5_pend", A_PEND, 32'h04);
    rdc("t5_unmapped_rd", 32'h040, 0);
    wr(32'h200, 32'h7);
    rdc("t5_unmapped_wr", A_TH, 0);

`ifdef PLIC_EDGE_TRIG_EN
    do_reset();
    wr(A_EDGE, 32'h02); wr(pa(1), 1); wr(A_EN, 32'h02);
    rdc("t6_edge_rb", A_EDGE, 32'h02);
    @(negedge clk); irq[0] = 1;
    @(negedge clk); irq[0] = 0;
    cycles(3);
    rdc("t6_pend", A_PEND, 32'h02);
    rdc("t6_claim", A_CLM, 1);
    repeat (3) begin
      @(negedge clk); irq[0] = 1;
      @(negedge clk); irq[0] = 0;
    end
    cycles(2);
    rdc("t6_held", A_PEND, 0);
    wr(A_CLM, 1);
    cycles(3);
    rdc("t6_repend", A_PEND, 32'h02);
    rdc("t6_claim2", A_CLM, 1);
    wr(A_CLM, 1);
    cycles(3);
    rdc("t6_once", A_PEND, 0);
`else
    do_reset();
    wr(A_EDGE, 32'h02);
    rdc("t6_no_edge", A_EDGE, 0);
`endif

    // Reset while a claim is outstanding
    do_reset();
    wr(pa(3), 2); wr(A_EN, 32'h08);
    @(negedge clk); irq[2] = 1;
    cycles(3);
    rdc("t7_claim", A_CLM, 3);
    do_reset();
    rdc("t7_prio", pa(3), 0);
    rdc("t7_en", A_EN, 0);
    rdc("t7_pend", A_PEND, 0);
    rdc("t7_claim0", A_CLM, 0);

    // Randomized rounds against the model
    do_reset();
    for (int i = 1; i <= N; i++) mst[i] = 0;
    for (int k = 0; k < 40; k++) begin
      for (int i = 1; i <= N; i++) begin
        mprio[i] = $urandom_range(0, 7);
        wr(pa(i), 32'(mprio[i]));
      end
      men = N'($urandom_range(0, 255));
      wr(A_EN, {23'b0, men, 1'b0});
      mthr = $urandom_range(0, 7);
      wr(A_TH, 32'(mthr));
      @(negedge clk); irq = N'($urandom_range(0, 255));
      cycles(3);
      settle();
      rdc("rnd_pend", A_PEND, mpend());
      chk("rnd_irq", {31'b0, irq_o}, mirq());
      w = mwin();
      rdc("rnd_claim", A_CLM, 32'(w));
      if (w != 0) mst[w] = 2;
      cycles(2);
      chk("rnd_irq_post", {31'b0, irq_o}, mirq());
      if (w != 0 && $urandom_range(0, 1) == 1) begin
        wr(A_CLM, 32'(w));
        mst[w] = 0;
        settle();
      end
      c = $urandom_range(0, 10);
      wr(A_CLM, 32'(c));
      if (c >= 1 && c <= N && mst[c] == 2) mst[c] = 0;
      settle();
    end
    cycles(2);
    rdc("rnd_final_pend", A_PEND, mpend());

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asr, n_fail);
    $finish;
  end

endmodule
